// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory controller between the EX/MEM register and the data cache.
// Define MEM_STAGE_PERF_CNT_EN to build the access and stall performance counters.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_store_data,
    input  logic                  i_pipe_advance,
    output logic                  o_dmem_read,
    output logic                  o_dmem_write,
    output logic [31:0]           o_dmem_address,
    output logic [31:0]           o_dmem_wdata,
    output logic [3:0]            o_dmem_mbe,
    input  logic [31:0]           i_dmem_rdata,
    input  logic                  i_dmem_resp,
    output logic                  o_mem_stall,
    output logic [31:0]           o_load_data,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    output logic [PERF_CNT_W-1:0] o_perf_access,
    output logic [PERF_CNT_W-1:0] o_perf_stall
);

    localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_dmem_read;
    logic              r_dmem_write;
    logic [31:0]       r_dmem_address;
    logic [31:0]       r_dmem_wdata;
    logic [3:0]        r_dmem_mbe;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic [31:0]       r_load_data;
    logic              r_bus_err;
    logic [WAIT_W-1:0] r_wait;

    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_access;
    logic              w_misaligned;
    logic              w_req;
    logic              w_timeout;
    logic              w_mem_stall;
    logic [3:0]        w_store_mbe;
    logic [3:0]        w_mbe;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_ext;

    // Size decode; the reserved encoding 2'b11 is handled as a word access.
    assign w_is_byte = (i_funct3[1:0] == 2'b00);
    assign w_is_half = (i_funct3[1:0] == 2'b01);
    assign w_is_word = i_funct3[1];

    // Gating with the reset keeps every combinational output low while reset is held.
    assign w_access     = (i_mem_read | i_mem_write) & i_rst_n;
    assign w_misaligned = w_access &
                          ((w_is_half & i_addr[0]) | (w_is_word & (i_addr[1:0] != 2'b00)));
    assign w_req        = w_access & ~w_misaligned;

    always_comb begin
        w_store_mbe = 4'hF;
        if (w_is_byte) begin
            w_store_mbe = 4'b0001 << i_addr[1:0];
        end else if (w_is_half) begin
            w_store_mbe = 4'b0011 << i_addr[1:0];
        end
    end

    assign w_mbe = i_mem_write ? w_store_mbe : 4'hF;

    // Each byte lane picks its source byte of rs2 for the access size; disabled lanes read 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] w_lane_src;

            always_comb begin
                w_lane_src = i_store_data[8*gi +: 8];
                if (w_is_byte) begin
                    w_lane_src = i_store_data[7:0];
                end else if (w_is_half) begin
                    w_lane_src = i_store_data[8*(gi%2) +: 8];
                end
            end

            assign w_wdata[8*gi +: 8] = (i_mem_write & w_store_mbe[gi]) ? w_lane_src : 8'h00;
        end
    endgenerate

    // Extension uses the size/sign and byte offset latched when the request was issued.
    always_comb begin
        w_shifted = i_dmem_rdata >> {r_lane, 3'b000};
        case (r_funct3[1:0])
            2'b00:   w_load_ext = {{24{~r_funct3[2] & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_ext = {{16{~r_funct3[2] & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = i_dmem_rdata;
        endcase
    end

    assign w_timeout   = (TIMEOUT != 0) && (r_wait == WAIT_LAST);
    assign w_mem_stall = (r_state == ST_ACCESS) | ((r_state == ST_IDLE) & w_req);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_mbe     <= '0;
            r_funct3       <= '0;
            r_lane         <= '0;
            r_load_data    <= '0;
            r_bus_err      <= 1'b0;
            r_wait         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state        <= ST_ACCESS;
                        r_dmem_read    <= ~i_mem_write;
                        r_dmem_write   <= i_mem_write;
                        r_dmem_address <= {i_addr[31:2], 2'b00};
                        r_dmem_wdata   <= w_wdata;
                        r_dmem_mbe     <= w_mbe;
                        r_funct3       <= i_funct3;
                        r_lane         <= i_addr[1:0];
                        r_wait         <= '0;
                    end
                end
                ST_ACCESS: begin
                    // A response arriving on the timeout cycle still completes normally.
                    if (i_dmem_resp) begin
                        r_state      <= ST_DONE;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_load_data  <= w_load_ext;
                    end else if (w_timeout) begin
                        r_state      <= ST_DONE;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_load_data  <= '0;
                        r_bus_err    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_pipe_advance) begin
                        r_state   <= ST_IDLE;
                        r_bus_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STAGE_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] r_perf_access;
    logic [PERF_CNT_W-1:0] r_perf_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_access <= '0;
            r_perf_stall  <= '0;
        end else begin
            if ((r_state == ST_ACCESS) && i_dmem_resp) begin
                r_perf_access <= r_perf_access + 1'b1;
            end
            if (w_mem_stall) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign o_perf_access = r_perf_access;
    assign o_perf_stall  = r_perf_stall;
`else
    assign o_perf_access = '0;
    assign o_perf_stall  = '0;
`endif

    assign o_dmem_read    = r_dmem_read;
    assign o_dmem_write   = r_dmem_write;
    assign o_dmem_address = r_dmem_address;
    assign o_dmem_wdata   = r_dmem_wdata;
    assign o_dmem_mbe     = r_dmem_mbe;
    assign o_mem_stall    = w_mem_stall;
    assign o_load_data    = r_load_data;
    assign o_misaligned   = w_misaligned;
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, random loads/stores against a
// reference model, and hand sequences for DONE hold, reset mid-access and timeout.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

`ifdef MEM_STAGE_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_read, mem_write, mem_read2;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, rdata;
    logic        pipe_adv, resp, resp2;

    logic        d_read, d_write, stall, mis, berr;
    logic [31:0] d_addr, d_wdata, load, pacc, pstl;
    logic [3:0]  d_mbe;

    logic        t_read, t_write, t_stall, t_mis, t_berr;
    logic [31:0] t_addr, t_wdata, t_load, t_pacc, t_pstl;
    logic [3:0]  t_mbe;

    mem_stage_ctrl #(.TIMEOUT(0), .PERF_CNT_W(32)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data), .i_pipe_advance(pipe_adv),
        .o_dmem_read(d_read), .o_dmem_write(d_write), .o_dmem_address(d_addr),
        .o_dmem_wdata(d_wdata), .o_dmem_mbe(d_mbe), .i_dmem_rdata(rdata), .i_dmem_resp(resp),
        .o_mem_stall(stall), .o_load_data(load), .o_misaligned(mis), .o_bus_err(berr),
        .o_perf_access(pacc), .o_perf_stall(pstl)
    );

    mem_stage_ctrl #(.TIMEOUT(8), .PERF_CNT_W(32)) u_dut_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mem_read2), .i_mem_write(1'b0),
        .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data), .i_pipe_advance(pipe_adv),
        .o_dmem_read(t_read), .o_dmem_write(t_write), .o_dmem_address(t_addr),
        .o_dmem_wdata(t_wdata), .o_dmem_mbe(t_mbe), .i_dmem_rdata(rdata), .i_dmem_resp(resp2),
        .o_mem_stall(t_stall), .o_load_data(t_load), .o_misaligned(t_mis), .o_bus_err(t_berr),
        .o_perf_access(t_pacc), .o_perf_stall(t_pstl)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_acc  = 0;
    int exp_stl  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdat;
        int          lat;
        int          hold;
        logic        mis;
        logic [3:0]  mbe;
        logic [31:0] wd;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: lanes, masks and extension from access size and byte offset.
    function automatic void ref_model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] sd, input logic [31:0] rdat,
                                      output logic m, output logic [3:0] mbe,
                                      output logic [31:0] wd, output logic [31:0] ld);
        int size, off;
        longint unsigned v, mask;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(a % 4);
        m    = ((a % size) != 0);
        mask = (64'd1 << (8 * size)) - 64'd1;
        if (wr) begin
            mbe = 4'(((1 << size) - 1) << off);
            wd  = 32'((longint'(sd) & mask) << (8 * off));
            ld  = '0;
        end else begin
            mbe = 4'hF;
            wd  = '0;
            v   = (longint'(rdat) >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
            ld  = 32'(v);
        end
    endfunction

    task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input int lat, input int hold, input logic e_mis,
                           input logic [3:0] e_mbe, input logic [31:0] e_wd, input logic [31:0] e_ld);
        int stalls, rcyc, wcyc, rises, dstall, dreq;
        logic prev_rd, g_mis;
        logic [31:0] g_addr, g_wd, g_ld;
        logic [3:0] g_mbe;
        g_addr = '0; g_wd = '0; g_mbe = '0; g_ld = '0; dstall = 0; dreq = 0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        resp = 1'b0; pipe_adv = 1'b0;
        @(negedge clk);
        g_mis = mis; stalls = int'(stall); rcyc = int'(d_read); wcyc = int'(d_write);
        prev_rd = d_read; rises = 0;
        chk({tag, ".misaligned"}, 32'(g_mis), 32'(e_mis));
        if (!e_mis) begin
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                resp  = (k == lat);
                rdata = (k == lat) ? rdat : $urandom;
                @(negedge clk);
                stalls += int'(stall);
                if (d_read) rcyc++;
                if (d_write) wcyc++;
                if (d_read && !prev_rd) rises++;
                prev_rd = d_read;
                if (k == 1) begin g_addr = d_addr; g_wd = d_wdata; g_mbe = d_mbe; end
            end
            @(posedge clk); #1;
            resp = 1'b0; rdata = $urandom;
            @(negedge clk);
            dstall = int'(stall); dreq = int'(d_read | d_write);
            chk({tag, ".bus_err"}, 32'(berr), 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                resp = 1'b1; rdata = $urandom;
                @(negedge clk);
                dstall += int'(stall); dreq += int'(d_read | d_write);
            end
            g_ld = load;
            @(posedge clk); #1;
            resp = 1'b0; pipe_adv = 1'b1;
            @(posedge clk); #1;
            pipe_adv = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            exp_acc++;
            exp_stl += 1 + lat;
            chk({tag, ".stall_cycles"}, 32'(stalls), 32'(1 + lat));
            chk({tag, ".read_cycles"}, 32'(rcyc), (rd && !wr) ? 32'(lat) : 32'd0);
            chk({tag, ".write_cycles"}, 32'(wcyc), wr ? 32'(lat) : 32'd0);
            chk({tag, ".read_issues"}, 32'(rises), (rd && !wr) ? 32'd1 : 32'd0);
            chk({tag, ".address"}, g_addr, a & 32'hFFFF_FFFC);
            chk({tag, ".mbe"}, 32'(g_mbe), 32'(e_mbe));
            if (wr) chk({tag, ".wdata"}, g_wd, e_wd);
            else    chk({tag, ".load_data"}, g_ld, e_ld);
            chk({tag, ".done_stall"}, 32'(dstall), 32'd0);
            chk({tag, ".done_reissue"}, 32'(dreq), 32'd0);
        end else begin
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            stalls += int'(stall); rcyc += int'(d_read); wcyc += int'(d_write);
            chk({tag, ".mis_stall"}, 32'(stalls), 32'd0);
            chk({tag, ".mis_request"}, 32'(rcyc + wcyc), 32'd0);
        end
        $display("txn %s rd=%0d wr=%0d f3=%03b addr=%08h mis=%0d stalls=%0d wdata=%08h mbe=%04b load=%08h",
                 tag, rd, wr, f3, a, g_mis, stalls, g_wd, g_mbe, g_ld);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] f3;
        logic wr, m;
        logic [31:0] a, sd, rd_word, wd, ld;
        logic [3:0] mbe;
        int sc, rc, early;

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        //            rd    wr    f3      addr        store_data    rdata         lat hold mis   mbe      wdata         load
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3,  0, 1'b0, 4'hF,    32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 1,  0, 1'b0, 4'hF,    32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFF7F, 2,  0, 1'b0, 4'hF,    32'h0,        32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h22,  32'h1234ABCD, 32'h0,        1,  0, 1'b0, 4'b1100, 32'hABCD0000, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1,  0, 1'b1, 4'hF,    32'h0,        32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 2,  0, 1'b0, 4'hF,    32'h0,        32'hFFFF8001};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h8001F234, 1,  0, 1'b0, 4'hF,    32'h0,        32'h0000F234};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'hFFFFFFA5, 32'h0,        2,  0, 1'b0, 4'b0010, 32'h0000A500, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h44,  32'hCAFEF00D, 32'h0,        1,  0, 1'b0, 4'hF,    32'hCAFEF00D, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h21,  32'h5555AAAA, 32'h0,        1,  0, 1'b1, 4'h0,    32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1,  3, 1'b0, 4'hF,    32'h0,        32'h0000007F};
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h8,   32'h0,        32'h0BADF00D, 10, 0, 1'b0, 4'hF,    32'h0,        32'h0BADF00D};

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_read2 = 1'b0; funct3 = '0;
        addr = '0; store_data = '0; rdata = '0; pipe_adv = 1'b0; resp = 1'b0; resp2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.dmem_read", 32'(d_read), 32'd0);
        chk("reset.mem_stall", 32'(stall), 32'd0);
        chk("reset.load_data", load, 32'd0);
        chk("reset.address", d_addr, 32'd0);
        chk("reset.perf_stall", pstl, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a,
                    vecs[i].sd, vecs[i].rdat, vecs[i].lat, vecs[i].hold, vecs[i].mis,
                    vecs[i].mbe, vecs[i].wd, vecs[i].ld);
        end

        for (int i = 0; i < 40; i++) begin
            wr      = 1'($urandom_range(0, 1));
            f3      = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a       = $urandom;
            sd      = $urandom;
            rd_word = $urandom;
            ref_model(wr, f3, a, sd, rd_word, m, mbe, wd, ld);
            run_txn($sformatf("rnd%0d", i), ~wr, wr, f3, a, sd, rd_word,
                    int'($urandom_range(1, 4)), 0, m, mbe, wd, ld);
        end

        @(negedge clk);
        chk("perf_access", pacc, PERF_ON ? 32'(exp_acc) : 32'd0);
        chk("perf_stall", pstl, PERF_ON ? 32'(exp_stl) : 32'd0);

        // Reset while the cache access is outstanding, then a stray response.
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.dmem_read", 32'(d_read), 32'd0);
        chk("rstmid.mem_stall", 32'(stall), 32'd0);
        chk("rstmid.mbe", 32'(d_mbe), 32'd0);
        chk("rstmid.perf_access", pacc, 32'd0);
        mem_read = 1'b0;
        exp_acc = 0; exp_stl = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        resp = 1'b1; rdata = 32'h5555_5555;
        @(negedge clk);
        chk("rstmid.late_read", 32'(d_read), 32'd0);
        chk("rstmid.late_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        resp = 1'b0;
        @(negedge clk);
        chk("rstmid.late_load", load, 32'd0);
        $display("txn rstmid reset during ACCESS, late response ignored load=%08h", load);
        run_txn("after_rst", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h1357_9BDF, 1, 0,
                1'b0, 4'hF, 32'h0, 32'h1357_9BDF);

        // Timeout instance: no response, abort after eight ACCESS cycles.
        @(posedge clk); #1;
        mem_read2 = 1'b1; funct3 = 3'b010; addr = 32'h200;
        sc = 0; rc = 0; early = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!t_stall) break;
            sc++;
            if (t_read) rc++;
            if (t_berr) early++;
            @(posedge clk); #1;
        end
        chk("timeout.stall_cycles", 32'(sc), 32'd9);
        chk("timeout.read_cycles", 32'(rc), 32'd8);
        chk("timeout.early_err", 32'(early), 32'd0);
        chk("timeout.bus_err", 32'(t_berr), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout.hold_err", 32'(t_berr), 32'd1);
        chk("timeout.no_reissue", 32'(t_read), 32'd0);
        @(posedge clk); #1;
        pipe_adv = 1'b1;
        @(posedge clk); #1;
        pipe_adv = 1'b0; mem_read2 = 1'b0;
        @(negedge clk);
        chk("timeout.err_cleared", 32'(t_berr), 32'd0);
        chk("timeout.idle_stall", 32'(t_stall), 32'd0);
        $display("txn timeout stall_cycles=%0d read_cycles=%0d", sc, rc);

        // Response on the same cycle as the timeout completes the access.
        @(posedge clk); #1;
        mem_read2 = 1'b1; funct3 = 3'b000; addr = 32'h203;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            resp2 = (k == 8);
            rdata = (k == 8) ? 32'h7F00_0000 : 32'hFFFF_FFFF;
            @(negedge clk);
        end
        chk("race.stall_on_8th", 32'(t_stall), 32'd1);
        @(posedge clk); #1;
        resp2 = 1'b0;
        @(negedge clk);
        chk("race.bus_err", 32'(t_berr), 32'd0);
        chk("race.stall", 32'(t_stall), 32'd0);
        chk("race.load_data", t_load, 32'h0000_007F);
        $display("txn race resp+timeout bus_err=%0d load=%08h", t_berr, t_load);
        @(posedge clk); #1;
        pipe_adv = 1'b1;
        @(posedge clk); #1;
        pipe_adv = 1'b0; mem_read2 = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
